// File: rtl/bht_predictor.sv
// Branch history/target table shared by fetch (lookup) and memory (update) stages.
// Tagged entries hold a saturating direction counter and a branch target.
// A lookup that hits the index being updated in the same cycle sees the new entry.
// Optional build macro BHT_STATS_EN adds committed-update and correct-prediction counters.
module bht_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 1024,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              flush,
`ifdef BHT_STATS_EN
    output logic [ADDR_W-1:0] flush_pc,
    output logic [31:0]       stat_total,
    output logic [31:0]       stat_right
`else
    output logic [ADDR_W-1:0] flush_pc
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WN  = CNT_W'(CNT_WT - CNT_W'(1));

    // Valid bits are the only reset state; the rest can map onto RAM.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [CNT_W-1:0]   cnt_mem [ENTRIES];
    logic [ADDR_W-1:0]  tgt_mem [ENTRIES];

    logic [IDX_W-1:0]  upd_idx, lk_idx;
    logic [TAG_W-1:0]  upd_tag, lk_tag;
    logic              actual, commit, upd_hit;
    logic [CNT_W-1:0]  old_cnt, new_cnt;
    logic [ADDR_W-1:0] new_tgt;

    logic              bypass, rd_valid, lk_hit, lk_taken;
    logic [TAG_W-1:0]  rd_tag;
    logic [CNT_W-1:0]  rd_cnt;
    logic [ADDR_W-1:0] rd_tgt, lk_tgt;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign lk_idx  = if_pc[IDX_W+1:2];
    assign lk_tag  = if_pc[ADDR_W-1:IDX_W+2];

    assign actual  = upd_is_jump | upd_taken;
    assign commit  = upd_valid & ~stall;

    // Misprediction: wrong direction, or taken with a wrong target.
    always_comb begin
        flush    = commit & ((actual != upd_pred_taken) |
                             (actual & (upd_pred_target != upd_target)));
        flush_pc = actual ? upd_target : upd_pc + ADDR_W'(4);
    end

    // Post-update entry contents for the resolved instruction.
    always_comb begin
        upd_hit = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);
        old_cnt = cnt_mem[upd_idx];
        new_cnt = old_cnt;
        new_tgt = upd_target;
        if (upd_hit) begin
            if (upd_is_jump)
                new_cnt = CNT_MAX;
            else if (upd_taken)
                new_cnt = (old_cnt == CNT_MAX) ? old_cnt : old_cnt + CNT_W'(1);
            else
                new_cnt = (old_cnt == '0) ? old_cnt : old_cnt - CNT_W'(1);
            if (!actual)
                new_tgt = tgt_mem[upd_idx];
        end else begin
            if (upd_is_jump)
                new_cnt = CNT_MAX;
            else
                new_cnt = actual ? CNT_WT : CNT_WN;
        end
    end

    // Lookup read with write-first forwarding from a same-index update.
    always_comb begin
        bypass   = commit && (upd_idx == lk_idx);
        rd_valid = bypass ? 1'b1    : valid_q[lk_idx];
        rd_tag   = bypass ? upd_tag : tag_mem[lk_idx];
        rd_cnt   = bypass ? new_cnt : cnt_mem[lk_idx];
        rd_tgt   = bypass ? new_tgt : tgt_mem[lk_idx];
        lk_hit   = rd_valid && (rd_tag == lk_tag);
        lk_taken = lk_hit && rd_cnt[CNT_W-1];
        lk_tgt   = lk_taken ? rd_tgt : if_pc + ADDR_W'(4);
    end

    // Registered prediction outputs, frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (!stall) begin
            pred_hit    <= lk_hit;
            pred_taken  <= lk_taken;
            pred_target <= lk_tgt;
        end
    end

    // Valid bit set on every committed update (hit or allocate).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= '0;
        else if (commit)
            valid_q[upd_idx] <= 1'b1;
    end

    // Entry payload write; gated by rst_n so an update racing reset is dropped.
    always_ff @(posedge clk) begin
        if (commit && rst_n) begin
            tag_mem[upd_idx] <= upd_tag;
            cnt_mem[upd_idx] <= new_cnt;
            tgt_mem[upd_idx] <= new_tgt;
        end
    end

`ifdef BHT_STATS_EN
    // Committed-update and correct-prediction counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total <= '0;
            stat_right <= '0;
        end else if (commit) begin
            stat_total <= stat_total + 32'd1;
            if (!flush)
                stat_right <= stat_right + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor: drivers push expected flush/lookup results,
// a negedge monitor pops and compares them when the DUT presents them.
module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        rst_n, stall;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        flush;
    logic [31:0] flush_pc;
`ifdef BHT_STATS_EN
    logic [31:0] stat_total, stat_right;
`endif

    always #5 clk = ~clk;

    bht_predictor dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .flush(flush),
`ifdef BHT_STATS_EN
        .flush_pc(flush_pc), .stat_total(stat_total), .stat_right(stat_right)
`else
        .flush_pc(flush_pc)
`endif
    );

    typedef struct packed { logic hit; logic tk; logic [31:0] tgt; } lk_t;
    typedef struct packed { logic fl; logic [31:0] pc; } fl_t;

    lk_t lk_q[$];
    fl_t fl_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    logic chk_upd = 1'b0, lk_issue = 1'b0, lk_present;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A lookup issued in one cycle is presented on the outputs in the next.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lk_present <= 1'b0;
        else        lk_present <= lk_issue;
    end

    // Monitor: compare DUT responses against the scoreboard queues.
    always @(negedge clk) begin
        if (chk_upd) begin
            if (fl_q.size() == 0) begin
                check("flush_queue_empty", 64'd1, 64'd0);
            end else begin
                fl_t e;
                e = fl_q.pop_front();
                check("flush", {63'd0, flush}, {63'd0, e.fl});
                if (e.fl) check("flush_pc", {32'd0, flush_pc}, {32'd0, e.pc});
            end
        end
        if (lk_present) begin
            if (lk_q.size() == 0) begin
                check("lookup_queue_empty", 64'd1, 64'd0);
            end else begin
                lk_t l;
                l = lk_q.pop_front();
                check("pred_hit",    {63'd0, pred_hit},    {63'd0, l.hit});
                check("pred_taken",  {63'd0, pred_taken},  {63'd0, l.tk});
                check("pred_target", {32'd0, pred_target}, {32'd0, l.tgt});
            end
        end
    end

    task automatic idle();
        stall = 0; if_pc = 0; upd_valid = 0; upd_pc = 0; upd_is_jump = 0;
        upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
        chk_upd = 0; lk_issue = 0;
        @(posedge clk); #1;
    endtask

    // One directed cycle: optional lookup, optional update, with hand-computed expectations.
    task automatic op(input logic lk, input logic [31:0] lpc,
                      input logic u, input logic [31:0] upc, input logic j, input logic t,
                      input logic [31:0] tg, input logic pt, input logic [31:0] ptg,
                      input logic st,
                      input logic eh, input logic et, input logic [31:0] etg,
                      input logic ef, input logic [31:0] efpc);
        stall = st; if_pc = lpc; upd_valid = u; upd_pc = upc; upd_is_jump = j;
        upd_taken = t; upd_target = tg; upd_pred_taken = pt; upd_pred_target = ptg;
        chk_upd = u; lk_issue = lk;
        if (u)  fl_q.push_back('{fl: ef, pc: efpc});
        if (lk) lk_q.push_back('{hit: eh, tk: et, tgt: etg});
        @(posedge clk); #1;
    endtask

    task automatic look(input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] etg);
        op(1, pc, 0, 0, 0, 0, 0, 0, 0, 0, eh, et, etg, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic j, input logic t, input logic [31:0] tg,
                       input logic pt, input logic [31:0] ptg, input logic ef, input logic [31:0] efpc);
        op(0, 0, 1, pc, j, t, tg, pt, ptg, 0, 0, 0, 0, ef, efpc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        idle();
        check("rst_hit",    {63'd0, pred_hit},    64'd0);
        check("rst_taken",  {63'd0, pred_taken},  64'd0);
        check("rst_target", {32'd0, pred_target}, 64'd0);
        check("rst_flush",  {63'd0, flush},       64'd0);
        rst_n = 1'b1;
        idle();

        // T1 cold miss, allocate weak-taken
        look(32'h100, 0, 0, 32'h104);
        upd(32'h100, 0, 1, 32'h180, 0, 32'h0, 1, 32'h180);
        look(32'h100, 1, 1, 32'h180);

        // T2 saturate then walk down
        repeat (3) upd(32'h100, 0, 1, 32'h180, 1, 32'h180, 0, 32'h0);
        look(32'h100, 1, 1, 32'h180);
        upd(32'h100, 0, 0, 32'h180, 1, 32'h180, 1, 32'h104);
        look(32'h100, 1, 1, 32'h180);
        upd(32'h100, 0, 0, 32'h180, 1, 32'h180, 1, 32'h104);
        look(32'h100, 1, 0, 32'h104);
`ifdef BHT_STATS_EN
        check("stat_total", {32'd0, stat_total}, 64'd6);
        check("stat_right", {32'd0, stat_right}, 64'd3);
`endif

        // T3 target mismatch with correct direction
        upd(32'h100, 0, 1, 32'h200, 1, 32'h180, 1, 32'h200);
        look(32'h100, 1, 1, 32'h200);
        upd(32'h100, 0, 0, 32'h200, 0, 32'h0, 0, 32'h0);
        look(32'h100, 1, 0, 32'h104);

        // T4 alias eviction
        upd(32'h1100, 0, 1, 32'h2000, 0, 32'h0, 1, 32'h2000);
        look(32'h1100, 1, 1, 32'h2000);
        look(32'h100, 0, 0, 32'h104);

        // T5 same-cycle bypass of a jump, then stalled update/lookup
        op(1, 32'h300, 1, 32'h300, 1, 0, 32'h40, 0, 32'h0, 0, 1, 1, 32'h40, 1, 32'h40);
        op(1, 32'h100, 1, 32'h100, 0, 1, 32'h500, 0, 32'h0, 1, 1, 1, 32'h40, 0, 32'h0);
        look(32'h100, 0, 0, 32'h104);
        look(32'h1100, 1, 1, 32'h2000);

        // PC wrap on +4 for both lookup fallthrough and flush redirect
        look(32'hFFFF_FFFC, 0, 0, 32'h0);
        upd(32'hFFFF_FFFC, 0, 0, 32'h10, 1, 32'h10, 1, 32'h0);
        look(32'hFFFF_FFFC, 1, 0, 32'h0);
        idle();

        // T6 reset asserted while an update is presented
        upd_valid = 1; upd_pc = 32'h700; upd_taken = 1; upd_target = 32'h900;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_hit",    {63'd0, pred_hit},    64'd0);
        check("midrst_taken",  {63'd0, pred_taken},  64'd0);
        check("midrst_target", {32'd0, pred_target}, 64'd0);
`ifdef BHT_STATS_EN
        check("midrst_total", {32'd0, stat_total}, 64'd0);
        check("midrst_right", {32'd0, stat_right}, 64'd0);
`endif
        idle();
        rst_n = 1'b1;
        idle();
        look(32'h1100, 0, 0, 32'h1104);
        look(32'h300, 0, 0, 32'h304);
        look(32'h100, 0, 0, 32'h104);
        look(32'h700, 0, 0, 32'h704);
        idle();
        idle();

        check("lk_queue_drained", 64'(lk_q.size()), 64'd0);
        check("fl_queue_drained", 64'(fl_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
